// File: rtl/ivector_pkg.sv
// Shared types for the IVector heard-indication serializer.
// Beat layout and FIFO entry format live here so the top and FIFO agree.
package ivector_pkg;

   localparam int unsigned NUM_CH_DEF = 10;
   localparam logic [7:0]  HDR_MAGIC  = 8'hA5;

   typedef struct packed {
      logic [7:0] seq;
      logic [7:0] meth;
      logic [7:0] len;
      logic [7:0] magic;
   } ser_hdr_t;

   // meth kept 8 bits wide so it drops straight into the header field
   typedef struct packed {
      logic [7:0]  meth;
      logic [31:0] v;
   } heard_ent_t;

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      PAY,
      CHK
   } ser_state_t;

endpackage

// File: rtl/ivector_sfifo.sv
// Small synchronous FIFO with a registered head entry (read straight from storage).
// Caller guarantees no enqueue when full and no dequeue when empty.
module ivector_sfifo #(
   parameter int unsigned W     = 40,
   parameter int unsigned DEPTH = 2
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         enq_i,
   input  logic [W-1:0] din_i,
   input  logic         deq_i,
   output logic [W-1:0] head_o,
   output logic         full_o,
   output logic         empty_o,
   output logic         single_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW:0]   cnt_q;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (enq_i) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= wr_q + 1'b1;
         end
         if (deq_i) begin
            rd_q <= rd_q + 1'b1;
         end
         case ({enq_i, deq_i})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign head_o   = mem_q[rd_q];
   assign full_o   = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o  = (cnt_q == '0);
   assign single_o = (cnt_q == (AW+1)'(1));

endmodule

// File: rtl/ivector_heard_serializer.sv
// Serialises buffered heard(meth, v) indications into header/payload[/checksum] 32-bit beats.
// Define IVECTOR_SER_CHKSUM_EN to append a header^payload checksum beat to every message.
module ivector_heard_serializer
   import ivector_pkg::*;
#(
   parameter int unsigned NUM_CH = NUM_CH_DEF,
   parameter int unsigned MW     = 4,
   parameter int unsigned DEPTH  = 2
) (
   input  logic          CLK,
   input  logic          nRST,
   input  logic          heard__ENA,
   output logic          heard__RDY,
   input  logic [MW-1:0] heard_meth,
   input  logic [31:0]   heard_v,
   output logic          beat_valid,
   input  logic          beat_ready,
   output logic [31:0]   beat_data,
   output logic          beat_last,
   input  logic [MW-1:0] cnt_sel,
   output logic [15:0]   cnt_value,
   output logic          err_meth
);

`ifdef IVECTOR_SER_CHKSUM_EN
   localparam logic [7:0] BEATS = 8'd3;
`else
   localparam logic [7:0] BEATS = 8'd2;
`endif

   ser_state_t  state_q, state_d;
   logic [7:0]  seq_q;
   logic [15:0] cnt_q [NUM_CH];
   logic        err_q;

   heard_ent_t  head;
   heard_ent_t  din;
   ser_hdr_t    hdr;
   logic        full, empty, single;
   logic        meth_ok, enq, last_fire, more;

   assign meth_ok   = (32'(heard_meth) < NUM_CH);
   assign heard__RDY = !full;
   assign enq       = heard__ENA && heard__RDY && meth_ok;
   assign din       = '{meth: 8'(heard_meth), v: heard_v};
   assign last_fire = beat_valid && beat_ready && beat_last;
   assign more      = !single || enq;
   assign err_meth  = err_q;

   ivector_sfifo #(
      .W    ($bits(heard_ent_t)),
      .DEPTH(DEPTH)
   ) u_fifo (
      .CLK     (CLK),
      .nRST    (nRST),
      .enq_i   (enq),
      .din_i   (din),
      .deq_i   (last_fire),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .single_o(single)
   );

   assign hdr = '{seq: seq_q, meth: head.meth, len: BEATS, magic: HDR_MAGIC};

   // IDLE jumps to HDR on the enqueue edge itself, so the header is valid one
   // cycle after the indication; the last beat hands over directly when more is queued.
   always_comb begin
      state_d    = state_q;
      beat_valid = 1'b0;
      beat_data  = '0;
      beat_last  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty || enq) state_d = HDR;
         end
         HDR: begin
            beat_valid = 1'b1;
            beat_data  = hdr;
            if (beat_ready) state_d = PAY;
         end
         PAY: begin
            beat_valid = 1'b1;
            beat_data  = head.v;
`ifdef IVECTOR_SER_CHKSUM_EN
            if (beat_ready) state_d = CHK;
`else
            beat_last  = 1'b1;
            if (beat_ready) state_d = more ? HDR : IDLE;
`endif
         end
`ifdef IVECTOR_SER_CHKSUM_EN
         CHK: begin
            beat_valid = 1'b1;
            beat_data  = hdr ^ head.v;
            beat_last  = 1'b1;
            if (beat_ready) state_d = more ? HDR : IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= IDLE;
         seq_q   <= '0;
         err_q   <= 1'b0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         if (heard__ENA && heard__RDY && !meth_ok) err_q <= 1'b1;
         if (last_fire) seq_q <= seq_q + 8'd1;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (last_fire && head.meth == 8'(i) && cnt_q[i] != 16'hFFFF) begin
               cnt_q[i] <= cnt_q[i] + 16'd1;
            end
         end
      end
   end

   always_comb begin
      cnt_value = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (32'(cnt_sel) == i) cnt_value = cnt_q[i];
      end
   end

endmodule
